pipelined_signed_adder: RTL and testbench
=========================================

Name: pipelined_signed_adder

Overview:
- Two-operand, sign-extending, registered adder.
- One parameterized block replaces the three fixed adder stages (Adder2, Adder3, Adder4) of the 8-channel I/Q DDC combining tree: 31→32, 32→33 and 33→34 bits.
- Instantiated seven times per I/Q rail; three levels combine eight 150 MHz FIR outputs into one 34-bit sum.
- The output width always grows by one bit, so the sum never overflows.

Parameters:
- IN_WIDTH, default 31: width of each two's-complement operand. Legal range 2..64.
- LATENCY, default 1: clock cycles from operand sample to result. Legal range 1..4.
  - For LATENCY > 1 the carry chain is split into LATENCY segments, with pipeline registers between segments.

Ports:
- clk, input, 1: rising-edge clock, the single clock domain.
- sclr_n, input, 1: synchronous reset, active low.
- ce, input, 1: clock enable, active high. The whole pipeline advances only when ce=1.
- in_valid, input, 1: marks a/b as a valid sample.
- a, input, IN_WIDTH: signed operand A.
- b, input, IN_WIDTH: signed operand B.
- s, output, IN_WIDTH+1: signed sum, equal to sign-extended a plus sign-extended b.
- out_valid, output, 1: in_valid delayed by LATENCY enabled cycles.

Behaviour:
- Arithmetic
  - Operands are two's complement.
  - Each operand is sign-extended to IN_WIDTH+1 bits before the add.
  - s is the exact sum; no saturation, truncation or rounding.
  - Range: -2^IN_WIDTH .. 2^IN_WIDTH-2.
- Latency
  - a/b are sampled on edge k when ce=1.
  - The matching s appears after LATENCY further enabled edges.
  - LATENCY=1: s is a single registered sum of the inputs.
- Segmented pipeline (LATENCY=L > 1)
  - Split IN_WIDTH+1 bits into L segments, each ceil((IN_WIDTH+1)/L) bits; the last segment takes the remainder.
  - Segment j is added in stage j using the registered carry from segment j-1.
  - Upper operand segments are delay-balanced; lower result segments are delayed to align.
  - Final s is bit-identical to the L=1 result delayed by L cycles.
- Throughput: one sample per enabled clock, no bubbles, no backpressure.
- Reset
  - While sclr_n=0 at a rising edge, clear every pipeline register to 0, including carries and valid bits. Reset has priority over ce.
  - s=0 and out_valid=0 from the first edge after assertion.
  - After release, the first result appears LATENCY enabled cycles after the first sampled input.
  - Reset mid-stream discards all in-flight samples.
- Clock enable
  - ce=0 freezes all stages, including s and out_valid; nothing is lost or duplicated.
  - Stalls of any length are transparent to the data sequence.
- Valid handling
  - in_valid rides alongside the data pipeline.
  - Data registers update regardless of in_valid, which gives lower power only via synthesis.
  - s is meaningful only when out_valid=1.
- Implementation
  - No combinational path from any input to any output.
  - No internal state beyond the pipeline registers.
  - Synthesizable, no vendor primitives.

Test Plan:
- Basic (IN_WIDTH=31, LATENCY=1, ce=1): a=1000, b=-3000 → s=-2000 and out_valid=1 exactly one edge later.
- Extremes, LATENCY 1..4: a=b=1073741823 → s=2147483646. a=b=-1073741824 → s=-2147483648. a=1073741823, b=-1073741824 → s=-1. Each result appears after LATENCY edges.
- Carry across segments (LATENCY=4, IN_WIDTH=33): a=0x0FFFFFFFF, b=1 → s=0x100000000 after 4 edges. Then stream 1000 random pairs back-to-back and compare every output against the golden sign-extended sum with a 4-cycle delay.
- ce stall: stream 5 pairs; drop ce for 3 cycles mid-stream. The output sequence equals the golden sequence with no loss or repeat, and s holds during the stall.
- Reset: drive sclr_n=0 for 1 edge with a pipeline full (LATENCY=3). s=0 and out_valid=0 next edge. Post-release, out_valid stays 0 until 3 edges after the first new in_valid.
- Width chaining: instantiate 7 blocks as the 8-input tree (31/32/33). Drive all 8 inputs at -1073741824 → final s=-8589934592 (34 bits) after 3×LATENCY edges.

Source files
------------

// File: rtl/pipelined_signed_adder_if.sv
// Operand/result bundle for one pipelined_signed_adder: two signed operands
// with a valid flag going in, the one-bit-wider sum and its valid coming out.
interface pipelined_signed_adder_if #(
  parameter int IN_WIDTH = 31
);
  logic                       in_valid;
  logic signed [IN_WIDTH-1:0] a;
  logic signed [IN_WIDTH-1:0] b;
  logic signed [IN_WIDTH:0]   s;
  logic                       out_valid;

  modport master (output in_valid, a, b, input s, out_valid);
  modport slave  (input in_valid, a, b, output s, out_valid);
endinterface

// File: rtl/pipelined_signed_adder.sv
// Registered two's-complement adder, output one bit wider than the operands.
// LATENCY=1 is a single registered add. For LATENCY>1 the sign-extended
// carry chain is cut into LATENCY slices of ceil((IN_WIDTH+1)/LATENCY) bits;
// slice k is added in stage k with the registered carry from slice k-1.
// Operands ride along so upper slices stay aligned, and finished lower
// slices are carried forward in the partial-sum register.
module pipelined_signed_adder #(
  parameter int IN_WIDTH = 31,
  parameter int LATENCY  = 1
) (
  input logic clk,
  input logic sclr_n,
  input logic ce,
  pipelined_signed_adder_if.slave bus
);
  localparam int W   = IN_WIDTH + 1;
  localparam int SEG = (W + LATENCY - 1) / LATENCY;

  logic [W-1:0]              a_x, b_x;
  logic [LATENCY-1:0][W-1:0] acc;
  logic [LATENCY-1:0]        vld_pipe;

  assign a_x           = {bus.a[IN_WIDTH-1], bus.a};
  assign b_x           = {bus.b[IN_WIDTH-1], bus.b};
  assign bus.s         = acc[LATENCY-1];
  assign bus.out_valid = vld_pipe[LATENCY-1];

  // valid flag shifts alongside the data, one flop per stage
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      vld_pipe <= '0;
    end else if (ce) begin
      vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  if (LATENCY == 1) begin : g_flat
    // whole sum in one registered add
    always_ff @(posedge clk) begin
      if (!sclr_n)  acc[0] <= '0;
      else if (ce)  acc[0] <= a_x + b_x;
    end
  end else begin : g_seg
    logic [LATENCY-2:0][W-1:0] op_a, op_b;
    logic [LATENCY-2:0]        cy;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stg
      // slice k covers bits [LO, HI); trailing slices may be empty when
      // LATENCY does not divide the width evenly
      localparam int LO = k * SEG;
      localparam int HI = ((k + 1) * SEG < W) ? (k + 1) * SEG : W;
      localparam logic [W-1:0] M = ({W{1'b1}} << LO) & ~({W{1'b1}} << HI);

      logic [W-1:0] pa, pb, pacc, t;
      logic         pcy;

      if (k == 0) begin : g_src
        assign pa   = a_x;
        assign pb   = b_x;
        assign pacc = '0;
        assign pcy  = 1'b0;
      end else begin : g_src
        assign pa   = op_a[k-1];
        assign pb   = op_b[k-1];
        assign pacc = acc[k-1];
        assign pcy  = cy[k-1];
      end

      // masking confines the adder to this slice; t[HI] is its carry out
      assign t = (pa & M) + (pb & M) + ({{(W-1){1'b0}}, pcy} << LO);

      // merge this slice into the partial sum, keep already-finished bits
      always_ff @(posedge clk) begin
        if (!sclr_n)  acc[k] <= '0;
        else if (ce)  acc[k] <= (pacc & ~M) | (t & M);
      end

      if (k < LATENCY - 1) begin : g_fwd
        logic co;
        if (HI < W) begin : g_co
          assign co = t[HI];
        end else begin : g_co
          assign co = 1'b0;
        end

        // hand operands and slice carry to the next stage
        always_ff @(posedge clk) begin
          if (!sclr_n) begin
            op_a[k] <= '0;
            op_b[k] <= '0;
            cy[k]   <= 1'b0;
          end else if (ce) begin
            op_a[k] <= pa;
            op_b[k] <= pb;
            cy[k]   <= co;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_signed_adder.sv
// Bench: four 31-bit adders (LATENCY 1..4), one 33-bit LATENCY=4 adder and a
// seven-block 8-input tree. Each has a delay-line model of "sign-extended sum,
// L enabled edges later" compared every cycle, plus literal spot checks.
module tb_pipelined_signed_adder;
  localparam int TL = 2;

  typedef struct { bit v; longint s; } smp_t;

  logic clk, sclr_n, ce, in_valid;
  logic signed [30:0] a, b;
  logic signed [32:0] a33, b33;
  logic signed [30:0] ta [8];
  int vecs = 0;
  int errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 31-bit adders at every latency, fed from the same stimulus
  for (genvar l = 1; l <= 4; l++) begin : g_lat
    pipelined_signed_adder_if #(.IN_WIDTH(31)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.a = a;
    assign bus.b = b;
    pipelined_signed_adder #(.IN_WIDTH(31), .LATENCY(l)) dut (
      .clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(bus));

    smp_t q[$];
    smp_t e;
    bit armed = 1'b0;
    always @(posedge clk) begin
      if (!sclr_n) begin
        q.delete();
        for (int i = 0; i < l - 1; i++) q.push_back('{1'b0, 64'sd0});
        e = '{1'b0, 64'sd0};
        armed = 1'b1;
      end else if (ce && armed) begin
        q.push_back('{in_valid, longint'(a) + longint'(b)});
        e = q.pop_front();
      end
    end
    always @(negedge clk) if (armed) begin
      chk($sformatf("lat%0d_s", l), bus.s, e.s);
      chk($sformatf("lat%0d_vld", l), bus.out_valid, e.v);
    end
  end

  // 33-bit, 4-stage adder
  pipelined_signed_adder_if #(.IN_WIDTH(33)) w33 ();
  assign w33.in_valid = in_valid;
  assign w33.a = a33;
  assign w33.b = b33;
  pipelined_signed_adder #(.IN_WIDTH(33), .LATENCY(4)) dut33 (
    .clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(w33));

  smp_t q33[$];
  smp_t e33;
  bit armed33 = 1'b0;
  always @(posedge clk) begin
    if (!sclr_n) begin
      q33.delete();
      for (int i = 0; i < 3; i++) q33.push_back('{1'b0, 64'sd0});
      e33 = '{1'b0, 64'sd0};
      armed33 = 1'b1;
    end else if (ce && armed33) begin
      q33.push_back('{in_valid, longint'(a33) + longint'(b33)});
      e33 = q33.pop_front();
    end
  end
  always @(negedge clk) if (armed33) begin
    chk("w33_s", w33.s, e33.s);
    chk("w33_vld", w33.out_valid, e33.v);
  end

  // 8-input combining tree: 31 -> 32 -> 33 -> 34 bits
  pipelined_signed_adder_if #(.IN_WIDTH(31)) t1_0 ();
  pipelined_signed_adder_if #(.IN_WIDTH(31)) t1_1 ();
  pipelined_signed_adder_if #(.IN_WIDTH(31)) t1_2 ();
  pipelined_signed_adder_if #(.IN_WIDTH(31)) t1_3 ();
  pipelined_signed_adder_if #(.IN_WIDTH(32)) t2_0 ();
  pipelined_signed_adder_if #(.IN_WIDTH(32)) t2_1 ();
  pipelined_signed_adder_if #(.IN_WIDTH(33)) t3 ();

  assign t1_0.in_valid = in_valid; assign t1_0.a = ta[0]; assign t1_0.b = ta[1];
  assign t1_1.in_valid = in_valid; assign t1_1.a = ta[2]; assign t1_1.b = ta[3];
  assign t1_2.in_valid = in_valid; assign t1_2.a = ta[4]; assign t1_2.b = ta[5];
  assign t1_3.in_valid = in_valid; assign t1_3.a = ta[6]; assign t1_3.b = ta[7];
  assign t2_0.in_valid = t1_0.out_valid; assign t2_0.a = t1_0.s; assign t2_0.b = t1_1.s;
  assign t2_1.in_valid = t1_2.out_valid; assign t2_1.a = t1_2.s; assign t2_1.b = t1_3.s;
  assign t3.in_valid   = t2_0.out_valid; assign t3.a   = t2_0.s; assign t3.b   = t2_1.s;

  pipelined_signed_adder #(.IN_WIDTH(31), .LATENCY(TL)) u1_0 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t1_0));
  pipelined_signed_adder #(.IN_WIDTH(31), .LATENCY(TL)) u1_1 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t1_1));
  pipelined_signed_adder #(.IN_WIDTH(31), .LATENCY(TL)) u1_2 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t1_2));
  pipelined_signed_adder #(.IN_WIDTH(31), .LATENCY(TL)) u1_3 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t1_3));
  pipelined_signed_adder #(.IN_WIDTH(32), .LATENCY(TL)) u2_0 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t2_0));
  pipelined_signed_adder #(.IN_WIDTH(32), .LATENCY(TL)) u2_1 (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t2_1));
  pipelined_signed_adder #(.IN_WIDTH(33), .LATENCY(TL)) u3   (.clk(clk), .sclr_n(sclr_n), .ce(ce), .bus(t3));

  smp_t qt[$];
  smp_t et;
  bit armedt = 1'b0;
  always @(posedge clk) begin
    longint sum;
    if (!sclr_n) begin
      qt.delete();
      for (int i = 0; i < 3 * TL - 1; i++) qt.push_back('{1'b0, 64'sd0});
      et = '{1'b0, 64'sd0};
      armedt = 1'b1;
    end else if (ce && armedt) begin
      sum = 0;
      for (int k = 0; k < 8; k++) sum += longint'(ta[k]);
      qt.push_back('{in_valid, sum});
      et = qt.pop_front();
    end
  end
  always @(negedge clk) if (armedt) begin
    chk("tree_s", t3.s, et.s);
    chk("tree_vld", t3.out_valid, et.v);
  end

  // one sample through every 31-bit latency, checked at its own arrival edge
  task automatic ext(input logic signed [30:0] x, input logic signed [30:0] y, input logic signed [63:0] sum);
    a = x; b = y; in_valid = 1'b1;
    tick(); chk("ext_l1", g_lat[1].bus.s, sum); chk("ext_l1_vld", g_lat[1].bus.out_valid, 1);
    a = '0; b = '0; in_valid = 1'b0;
    tick(); chk("ext_l2", g_lat[2].bus.s, sum); chk("ext_l2_vld", g_lat[2].bus.out_valid, 1);
    tick(); chk("ext_l3", g_lat[3].bus.s, sum); chk("ext_l3_vld", g_lat[3].bus.out_valid, 1);
    tick(); chk("ext_l4", g_lat[4].bus.s, sum); chk("ext_l4_vld", g_lat[4].bus.out_valid, 1);
  endtask

  initial begin
    sclr_n = 1'b0; ce = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; a33 = '0; b33 = '0;
    for (int k = 0; k < 8; k++) ta[k] = '0;
    tick(); tick();
    chk("rst_s", g_lat[4].bus.s, 0);
    chk("rst_vld", g_lat[4].bus.out_valid, 0);
    sclr_n = 1'b1;

    // basic
    a = 31'sd1000; b = -31'sd3000; in_valid = 1'b1;
    tick();
    chk("basic_s", g_lat[1].bus.s, -64'sd2000);
    chk("basic_vld", g_lat[1].bus.out_valid, 1);

    // extremes
    ext(31'sd1073741823, 31'sd1073741823, 64'sd2147483646);
    ext(31'sh40000000, 31'sh40000000, -64'sd2147483648);
    ext(31'sd1073741823, 31'sh40000000, -64'sd1);

    // carry across all four slices of a 34-bit sum
    a33 = 33'h0FFFFFFFF; b33 = 33'sd1; in_valid = 1'b1;
    tick();
    a33 = '0; b33 = '0; in_valid = 1'b0;
    tick(); tick(); tick();
    chk("carry33_s", w33.s, 64'sh100000000);
    chk("carry33_vld", w33.out_valid, 1);

    // back-to-back random stream
    for (int i = 0; i < 1000; i++) begin
      a = 31'($urandom); b = 31'($urandom);
      a33 = 33'({$urandom, $urandom}); b33 = 33'({$urandom, $urandom});
      for (int k = 0; k < 8; k++) ta[k] = 31'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; a = '0; b = '0; a33 = '0; b33 = '0;
    for (int k = 0; k < 8; k++) ta[k] = '0;
    repeat (6) tick();

    // ce stall mid-stream; inputs toggle during the stall and must be ignored
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        ce = 1'b0; a = 31'sd777; b = -31'sd5;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("stall_hold", g_lat[1].bus.s, 64'sd22);
        end
        ce = 1'b1;
      end
      a = 31'(i * 10); b = 31'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; a = '0; b = '0;
    repeat (5) tick();

    // reset with a full pipeline, asserted while ce=0
    for (int i = 0; i < 3; i++) begin
      a = 31'(100 + i); b = 31'sd1; in_valid = 1'b1;
      tick();
    end
    ce = 1'b0; sclr_n = 1'b0;
    tick();
    chk("midrst_s", g_lat[3].bus.s, 0);
    chk("midrst_vld", g_lat[3].bus.out_valid, 0);
    sclr_n = 1'b1; ce = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    tick(); tick();
    a = 31'sd5; b = 31'sd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    tick();
    chk("postrst_vld2", g_lat[3].bus.out_valid, 0);
    tick();
    chk("postrst_vld3", g_lat[3].bus.out_valid, 1);
    chk("postrst_s3", g_lat[3].bus.s, 64'sd11);

    // tree at full negative scale
    for (int k = 0; k < 8; k++) ta[k] = 31'sh40000000;
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) ta[k] = '0;
    in_valid = 1'b0;
    repeat (3 * TL - 1) tick();
    chk("tree_min_s", t3.s, -64'sd8589934592);
    chk("tree_min_vld", t3.out_valid, 1);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
